idu_queue: RTL and testbench
============================

IDU_QUEUE -- requirements
Module: idu_queue

Interface
Parameters:
REQ-001 XLEN, 32, data/immediate width; SHALL be 32 or 64, with immediates sign-extended to XLEN.
REQ-002 DEPTH, 4, instruction buffer entries; SHALL be a power of two, 2..16.
REQ-003 EN_M, 0, when 1 SHALL decode RV M-extension (funct7=0000001, OP opcode) as legal; when 0 SHALL flag it illegal.

Ports:
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discard all buffered instructions.
REQ-007 reqValid  in  1  fetch offers an instruction.
REQ-008 reqReady  out  1  buffer can accept an instruction.
REQ-009 inst_in  in  32  raw instruction.
REQ-010 pc_in  in  XLEN  address of inst_in.
REQ-011 respValid  out  1  decoded head entry is valid.
REQ-012 respReady  in  1  consumer takes the head entry.
REQ-013 pc, rd, rs1, rs2, imm, alu_op, com_op, inst_type  out  XLEN/5/5/5/XLEN/pkg/pkg/pkg  decoded fields of the head entry.
REQ-014 mul_div  out  1  head entry is an M-extension op (only when EN_M=1, else 0).
REQ-015 illegal  out  1  head entry is not a supported encoding.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Transfers SHALL occur on a cycle with valid&ready high at a rising edge; both handshake sides are independent.
REQ-018 reqReady SHALL be (count<DEPTH) || respReady, so a push into a full buffer is accepted in the same cycle as a pop.
REQ-019 respValid SHALL equal (count!=0); outputs SHALL be combinational decode of the head entry and stable while respValid && !respReady.
REQ-020 Latency: an instruction pushed into an empty buffer at edge N SHALL present respValid=1 after edge N; there is no bypass in the same cycle.
REQ-021 Order SHALL be strict FIFO, with read/write pointers wrapping modulo DEPTH.
REQ-022 Push+pop in the same cycle SHALL leave count unchanged, including at count=DEPTH and count=1.
REQ-023 A pop with count=0 and a push with reqReady=0 SHALL be ignored with no state change.
REQ-024 flush SHALL set count=0 and both pointers to 0 at the next edge; any same-cycle push and pop SHALL be discarded.
REQ-025 Decode fields SHALL be: I/S/B/U/J immediates per the RV32I base spec; OP-IMM alu_op={inst[30]&funct3==101, funct3}; OP alu_op={inst[30]&(funct3==000||101), funct3}; LUI alu_op=ALU_OP_RHS; BRANCH com_op=funct3; SYSTEM alu_op={funct3[0],funct3[1],2'b10}; LOAD/STORE inst_type carries funct3; all others alu_op=ALU_OP_ADD, com_op=COM_OP_ONE.
REQ-026 illegal SHALL be 1 for any of: inst[1:0]!=11; unlisted opcode; OP funct7 not in {0000000, 0100000 with funct3 in {000,101}, 0000001 when EN_M}; OP-IMM shift with inst[31:26] other than 000000/010000 (XLEN=64) or inst[31:25] (XLEN=32); LOAD funct3 in {011,110,111} when XLEN=32, or 111 when XLEN=64; STORE funct3>=011 when XLEN=32, or >=100 when XLEN=64; BRANCH funct3 in {010,011}.
REQ-027 An illegal entry SHALL output inst_type=0, imm=0 and still handshake normally.

Reset
REQ-028 While reset is 1 at an edge: count=0, pointers=0, respValid=0, reqReady=1; reset SHALL override flush, push and pop.
REQ-029 Buffer storage SHALL NOT require reset; outputs other than respValid/reqReady/count are don't-care while respValid=0.
REQ-030 Reset asserted mid-stream SHALL drop all entries, and the first post-reset push SHALL be entry 0.

Structure
REQ-031 Opcode constants, ALU_OP_*, COM_OP_*, INST_* codes and their widths SHALL live in one shared package used by idu_queue and the execute stage.
REQ-032 Storage SHALL be a sub-module inst_fifo (parameter WIDTH, DEPTH; ports push/pop/flush/full/empty/count), with decode as combinational logic in idu_queue.

Verification
REQ-033 Push addi x1,x2,5 (0x00510093, pc 0x100) into an empty buffer -> respValid next cycle; rd=1, rs1=2, imm=5, alu_op=ADD, pc=0x100, illegal=0.
REQ-034 Push lui x5,0x12345 (0x123452B7), then sub x3,x1,x2 (0x402081B3) with respReady=0 -> count=2, head=LUI imm=0x12345000, alu_op=RHS; after one pop the head is SUB, alu_op={1,000}.
REQ-035 Fill DEPTH=4 with respReady=0 -> reqReady=1 only when respReady=1; a simultaneous push+pop at full keeps count=4 and preserves order across pointer wrap.
REQ-036 Push 0xFFFFFFFF and 0x02208033 (mul) with EN_M=0 -> illegal=1 for both; with EN_M=1 the mul gives illegal=0, mul_div=1.
REQ-037 count=3 with flush and reqValid both high -> count=0 next cycle and respValid=0; the next push appears alone.
REQ-038 Reset asserted at count=2 during a push -> count=0 and reqReady=1 after the edge, and no stale entry is ever output.

Source files
------------

// File: rtl/idu_queue_pkg.sv
// Shared decode vocabulary for the instruction queue and execute stage:
// RV opcodes, ALU/compare operation codes and instruction class codes.
package idu_queue_pkg;

    localparam int ALU_OP_W    = 4;
    localparam int COM_OP_W    = 3;
    localparam int INST_CLS_W  = 4;
    localparam int INST_TYPE_W = INST_CLS_W + 3;

    typedef logic [ALU_OP_W-1:0]    alu_op_t;
    typedef logic [COM_OP_W-1:0]    com_op_t;
    typedef logic [INST_TYPE_W-1:0] inst_type_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // {1,011} is never produced by OP/OP-IMM, so it is free for "pass rhs".
    localparam alu_op_t ALU_OP_ADD = 4'b0000;
    localparam alu_op_t ALU_OP_RHS = 4'b1011;

    // 010 is not a legal branch funct3, so it is free for "always true".
    localparam com_op_t COM_OP_ONE = 3'b010;

    typedef enum logic [INST_CLS_W-1:0] {
        INST_NONE    = 4'd0,
        INST_ALU_REG = 4'd1,
        INST_ALU_IMM = 4'd2,
        INST_AUIPC   = 4'd3,
        INST_JAL     = 4'd4,
        INST_JALR    = 4'd5,
        INST_BRANCH  = 4'd6,
        INST_LOAD    = 4'd7,
        INST_STORE   = 4'd8,
        INST_FENCE   = 4'd9,
        INST_SYSTEM  = 4'd10
    } inst_cls_e;

    // Low three bits carry the memory access funct3 for loads and stores.
    function automatic inst_type_t mk_inst_type(input inst_cls_e cls, input logic [2:0] f3);
        return {cls, f3};
    endfunction

endpackage

// File: rtl/idu_queue_fifo.sv
// Instruction buffer storage: circular FIFO with wrapping pointers,
// simultaneous push/pop at full, and a flush that empties it.
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale words are never visible while empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/idu_queue.sv
// Instruction decode queue: buffers fetched instructions and presents the
// combinational decode of the head entry to the execute stage.
module idu_queue
    import idu_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter bit EN_M  = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [31:0]            inst_in,
    input  logic [XLEN-1:0]        pc_in,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [XLEN-1:0]        pc,
    output logic [4:0]             rd,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [XLEN-1:0]        imm,
    output alu_op_t                alu_op,
    output com_op_t                com_op,
    output inst_type_t             inst_type,
    output logic                   mul_div,
    output logic                   illegal,
    output logic [$clog2(DEPTH):0] count
);
    localparam int EW = XLEN + 32;

    // Handshake: a side transfers at a rising edge where its valid and ready
    // are both high; push and pop are independent of each other.
    logic [EW-1:0]      head;
    logic               full, empty, push, pop;
    logic [31:0]        inst;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm32;
    logic [31:0]        i_imm;

    assign reqReady  = !full || respReady;
    assign respValid = !empty;
    assign push      = reqValid && reqReady;
    assign pop       = respValid && respReady;

    inst_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({pc_in, inst_in}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign inst  = head[31:0];
    assign pc    = head[EW-1:32];
    assign rd    = inst[11:7];
    assign rs1   = inst[19:15];
    assign rs2   = inst[24:20];
    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign imm   = XLEN'(imm32);

    always_comb begin
        opcode    = inst[6:0];
        funct3    = inst[14:12];
        funct7    = inst[31:25];
        imm32     = '0;
        alu_op    = ALU_OP_ADD;
        com_op    = COM_OP_ONE;
        inst_type = mk_inst_type(INST_NONE, 3'b000);
        mul_div   = 1'b0;
        illegal   = 1'b0;
        // Opcodes all end in 2'b11, so a non-32-bit encoding lands in default.
        case (opcode)
            OPC_LUI: begin
                imm32     = {inst[31:12], 12'b0};
                alu_op    = ALU_OP_RHS;
                inst_type = mk_inst_type(INST_ALU_IMM, 3'b000);
            end
            OPC_AUIPC: begin
                imm32     = {inst[31:12], 12'b0};
                inst_type = mk_inst_type(INST_AUIPC, 3'b000);
            end
            OPC_JAL: begin
                imm32     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                inst_type = mk_inst_type(INST_JAL, 3'b000);
            end
            OPC_JALR: begin
                imm32     = i_imm;
                inst_type = mk_inst_type(INST_JALR, 3'b000);
            end
            OPC_BRANCH: begin
                imm32     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                com_op    = funct3;
                inst_type = mk_inst_type(INST_BRANCH, 3'b000);
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                imm32     = i_imm;
                inst_type = mk_inst_type(INST_LOAD, funct3);
                illegal   = (XLEN == 32) ? (funct3 inside {3'b011, 3'b110, 3'b111})
                                         : (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm32     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                inst_type = mk_inst_type(INST_STORE, funct3);
                illegal   = (XLEN == 32) ? (funct3 >= 3'b011) : (funct3 >= 3'b100);
            end
            OPC_OP_IMM: begin
                imm32     = i_imm;
                alu_op    = {inst[30] && (funct3 == 3'b101), funct3};
                inst_type = mk_inst_type(INST_ALU_IMM, 3'b000);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (XLEN == 64) begin
                        illegal = !(inst[31:26] inside {6'b000000, 6'b010000});
                    end else begin
                        illegal = !(funct7 inside {7'b0000000, 7'b0100000});
                    end
                end
            end
            OPC_OP: begin
                alu_op    = {inst[30] && (funct3 == 3'b000 || funct3 == 3'b101), funct3};
                inst_type = mk_inst_type(INST_ALU_REG, 3'b000);
                mul_div   = EN_M && (funct7 == 7'b0000001);
                illegal   = !((funct7 == 7'b0000000) ||
                              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                              mul_div);
            end
            OPC_MISC_MEM: begin
                imm32     = i_imm;
                inst_type = mk_inst_type(INST_FENCE, 3'b000);
            end
            OPC_SYSTEM: begin
                imm32     = i_imm;
                alu_op    = {funct3[0], funct3[1], 2'b10};
                inst_type = mk_inst_type(INST_SYSTEM, 3'b000);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            imm32     = '0;
            inst_type = mk_inst_type(INST_NONE, 3'b000);
            mul_div   = 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_queue.sv
// Self-checking bench for idu_queue: directed scenarios plus random traffic,
// scored against a queue-based model and a field-level RV decoder.
module tb_idu_queue;
    import idu_queue_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int W     = 64;

    typedef struct {
        bit          illegal;
        bit          mul_div;
        logic [3:0]  alu;
        logic [2:0]  com;
        logic [6:0]  itype;
        logic [31:0] imm;
    } dec_t;

    logic clock, reset, flush, reqValid, respReady;
    logic [31:0]     inst_in;
    logic [XLEN-1:0] pc_in;

    logic reqReady, respValid, mul_div, illegal;
    logic [XLEN-1:0] pc, imm;
    logic [4:0] rd, rs1, rs2;
    alu_op_t alu_op;
    com_op_t com_op;
    inst_type_t inst_type;
    logic [$clog2(DEPTH):0] count;

    logic reqReady_m, respValid_m, mul_div_m, illegal_m;
    logic [XLEN-1:0] pc_m, imm_m;
    logic [4:0] rd_m, rs1_m, rs2_m;
    alu_op_t alu_op_m;
    com_op_t com_op_m;
    inst_type_t inst_type_m;
    logic [$clog2(DEPTH):0] count_m;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;

    idu_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1'b0)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .reqValid(reqValid), .reqReady(reqReady), .inst_in(inst_in), .pc_in(pc_in),
        .respValid(respValid), .respReady(respReady),
        .pc(pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .alu_op(alu_op), .com_op(com_op), .inst_type(inst_type),
        .mul_div(mul_div), .illegal(illegal), .count(count)
    );

    idu_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1'b1)) dut_m (
        .clock(clock), .reset(reset), .flush(flush),
        .reqValid(reqValid), .reqReady(reqReady_m), .inst_in(inst_in), .pc_in(pc_in),
        .respValid(respValid_m), .respReady(respReady),
        .pc(pc_m), .rd(rd_m), .rs1(rs1_m), .rs2(rs2_m), .imm(imm_m),
        .alu_op(alu_op_m), .com_op(com_op_m), .inst_type(inst_type_m),
        .mul_div(mul_div_m), .illegal(illegal_m), .count(count_m)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decoder built from the RV field definitions with plain arithmetic.
    function automatic dec_t model_dec(input logic [31:0] w, input bit en_m);
        dec_t d;
        int unsigned f3 = w[14:12];
        int unsigned f7 = w[31:25];
        int sw = int'(w);
        d.illegal = 0; d.mul_div = 0; d.alu = ALU_OP_ADD; d.com = COM_OP_ONE;
        d.itype = 7'd0; d.imm = 32'd0;
        case (w[6:0])
            7'h37: begin d.imm = w & 32'hFFFFF000; d.alu = ALU_OP_RHS; d.itype = {INST_ALU_IMM, 3'b000}; end
            7'h17: begin d.imm = w & 32'hFFFFF000; d.itype = {INST_AUIPC, 3'b000}; end
            7'h6F: begin
                d.imm = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                        + int'(w[30:21]) * 2;
                d.itype = {INST_JAL, 3'b000};
            end
            7'h67: begin d.imm = sw >>> 20; d.itype = {INST_JALR, 3'b000}; end
            7'h63: begin
                d.imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                        + int'(w[11:8]) * 2;
                d.com = w[14:12];
                d.itype = {INST_BRANCH, 3'b000};
                d.illegal = (f3 == 2 || f3 == 3);
            end
            7'h03: begin d.imm = sw >>> 20; d.itype = {INST_LOAD, w[14:12]}; d.illegal = (f3 == 3 || f3 >= 6); end
            7'h23: begin
                d.imm = (sw >>> 25) * 32 + int'(w[11:7]);
                d.itype = {INST_STORE, w[14:12]};
                d.illegal = (f3 >= 3);
            end
            7'h13: begin
                d.imm = sw >>> 20;
                d.alu = 4'(((w[30] && f3 == 5) ? 8 : 0) + f3);
                d.itype = {INST_ALU_IMM, 3'b000};
                if (f3 == 1 || f3 == 5) d.illegal = !(f7 == 0 || f7 == 32);
            end
            7'h33: begin
                d.alu = 4'(((w[30] && (f3 == 0 || f3 == 5)) ? 8 : 0) + f3);
                d.itype = {INST_ALU_REG, 3'b000};
                d.mul_div = en_m && f7 == 1;
                d.illegal = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (en_m && f7 == 1));
            end
            7'h0F: begin d.imm = sw >>> 20; d.itype = {INST_FENCE, 3'b000}; end
            7'h73: begin
                d.imm = sw >>> 20;
                d.alu = 4'((f3 & 1) * 8 + ((f3 >> 1) & 1) * 4 + 2);
                d.itype = {INST_SYSTEM, 3'b000};
            end
            default: d.illegal = 1;
        endcase
        if (d.illegal) begin d.imm = 0; d.itype = 0; d.mul_div = 0; end
        return d;
    endfunction

    task automatic check_head(input string sfx, input bit en_m, input logic [31:0] o_pc,
                              input logic [4:0] o_rd, input logic [4:0] o_rs1, input logic [4:0] o_rs2,
                              input logic [31:0] o_imm, input logic [3:0] o_alu, input logic [2:0] o_com,
                              input logic [6:0] o_ty, input logic o_md, input logic o_ill);
        logic [W-1:0] e = exp_q[0];
        dec_t d = model_dec(e[31:0], en_m);
        check({"pc", sfx}, 64'(o_pc), 64'(e[63:32]));
        check({"rd", sfx}, 64'(o_rd), 64'(e[11:7]));
        check({"rs1", sfx}, 64'(o_rs1), 64'(e[19:15]));
        check({"rs2", sfx}, 64'(o_rs2), 64'(e[24:20]));
        check({"illegal", sfx}, 64'(o_ill), 64'(d.illegal));
        check({"mul_div", sfx}, 64'(o_md), 64'(d.mul_div));
        check({"inst_type", sfx}, 64'(o_ty), 64'(d.itype));
        check({"imm", sfx}, 64'(o_imm), 64'(d.imm));
        if (!d.illegal) begin
            check({"alu_op", sfx}, 64'(o_alu), 64'(d.alu));
            check({"com_op", sfx}, 64'(o_com), 64'(d.com));
        end
    endtask

    task automatic check_outputs();
        int n = exp_q.size();
        check("count", 64'(count), 64'(n));
        check("count_m", 64'(count_m), 64'(n));
        check("resp_valid", 64'(respValid), 64'(n != 0));
        check("resp_valid_m", 64'(respValid_m), 64'(n != 0));
        check("req_ready", 64'(reqReady), 64'(n < DEPTH || respReady));
        check("req_ready_m", 64'(reqReady_m), 64'(n < DEPTH || respReady));
        if (n != 0) begin
            check_head("", 1'b0, pc, rd, rs1, rs2, imm, alu_op, com_op, inst_type, mul_div, illegal);
            check_head("_m", 1'b1, pc_m, rd_m, rs1_m, rs2_m, imm_m, alu_op_m, com_op_m, inst_type_m,
                       mul_div_m, illegal_m);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit fl, input bit rv, input logic [31:0] ins,
                        input logic [31:0] p, input bit rr);
        bit do_push, do_pop;
        reset = rst; flush = fl; reqValid = rv; inst_in = ins; pc_in = p; respReady = rr;
        do_push = rv && (exp_q.size() < DEPTH || rr);
        do_pop  = (exp_q.size() != 0) && rr;
        @(posedge clock);
        if (rst || fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({p, ins});
        end
        #1;
        check_outputs();
    endtask

    task automatic push1(input logic [31:0] ins, input logic [31:0] p);
        step(0, 0, 1, ins, p, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) step(0, 0, 0, 32'd0, 32'd0, 1);
        check("drained", 64'(count), 64'd0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs [11];
        logic [31:0] w;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom();
        if ($urandom_range(0, 9) != 0) begin
            w[6:0] = opcs[$urandom_range(0, 10)];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rpc;
        reset = 1; flush = 0; reqValid = 0; respReady = 0; inst_in = '0; pc_in = '0;
        step(1, 0, 0, 32'd0, 32'd0, 0);
        step(1, 0, 1, 32'h00000013, 32'h0, 1);
        check("reset_ready", 64'(reqReady), 64'd1);

        // addi x1,x2,5
        push1(32'h00510093, 32'h100);
        check("addi_valid", 64'(respValid), 64'd1);
        check("addi_rd", 64'(rd), 64'd1);
        check("addi_rs1", 64'(rs1), 64'd2);
        check("addi_imm", 64'(imm), 64'd5);
        check("addi_alu", 64'(alu_op), 64'(ALU_OP_ADD));
        check("addi_pc", 64'(pc), 64'h100);
        drain();

        // lui then sub, consumer stalled
        push1(32'h123452B7, 32'h104);
        push1(32'h402081B3, 32'h108);
        check("lui_imm", 64'(imm), 64'h12345000);
        check("lui_alu", 64'(alu_op), 64'(ALU_OP_RHS));
        step(0, 0, 0, 32'd0, 32'd0, 1);
        check("sub_alu", 64'(alu_op), 64'b1000);
        drain();

        // fill, full backpressure, push+pop at full across pointer wrap
        for (int i = 0; i < DEPTH + 1; i++) push1(32'h00100093 + (i << 20), 32'h200 + 4 * i);
        check("full_ready_lo", 64'(reqReady), 64'd0);
        respReady = 1; #1;
        check("full_ready_hi", 64'(reqReady), 64'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 32'h00A00113 + (i << 20), 32'h300 + 4 * i, 1);
        check("full_swap_count", 64'(count), 64'd4);
        drain();

        // illegal word and mul
        push1(32'hFFFFFFFF, 32'h400);
        push1(32'h02208033, 32'h404);
        check("ones_ill", 64'(illegal), 64'd1);
        check("ones_ill_m", 64'(illegal_m), 64'd1);
        step(0, 0, 0, 32'd0, 32'd0, 1);
        check("mul_ill", 64'(illegal), 64'd1);
        check("mul_ill_m", 64'(illegal_m), 64'd0);
        check("mul_md_m", 64'(mul_div_m), 64'd1);
        drain();

        // flush with concurrent push and pop
        for (int i = 0; i < 3; i++) push1(32'h00000013, 32'h500 + 4 * i);
        step(0, 1, 1, 32'h00100013, 32'h50C, 1);
        check("flush_count", 64'(count), 64'd0);
        push1(32'h00200013, 32'h510);
        check("flush_next_pc", 64'(pc), 64'h510);
        drain();

        // reset mid-stream during a push
        push1(32'h00000013, 32'h600);
        push1(32'h00000013, 32'h604);
        step(1, 0, 1, 32'h00000013, 32'h608, 0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(reqReady), 64'd1);
        push1(32'h00300013, 32'h60C);
        check("rst_next_pc", 64'(pc), 64'h60C);
        drain();

        // random traffic
        rpc = 32'h1000;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, rand_inst(), rpc, $urandom_range(0, 2) != 0);
            rpc += 4;
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
